// File: rtl/imem_write_buffer.sv
// Store-side IMEM writer: queues MEM-stage stores that hit the IMEM window and
// drains them into the IMEM write port on cycles when fetch leaves the port idle.
module imem_write_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    input  logic [31:0]       st_addr,
    input  logic [31:0]       st_data,
    input  logic [3:0]        st_be,
    output logic              st_ready,
    input  logic              fetch_busy,
    input  logic [31:0]       fetch_pc,
    output logic [3:0]        imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    output logic              pending,
    output logic              fetch_hold,
    output logic              drain_force
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] DEPTH_C      = CNT_W'(DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX_C = STV_W'(STARVE_MAX);

    // Stores land in IMEM for byte addresses 0x2xxx_xxxx and 0x3xxx_xxxx.
    function automatic logic in_store_window(input logic [31:0] addr);
        return (addr[31:29] == 3'b001);
    endfunction

    logic [ADDR_W-1:0] addr_mem_r [DEPTH];
    logic [31:0]       data_mem_r [DEPTH];
    logic [3:0]        be_mem_r   [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic [STV_W-1:0]  starve_r;

    logic empty_s;
    logic full_s;
    logic pop_s;
    logic push_s;
    logic hold_match_s;

    assign empty_s = (count_r == {CNT_W{1'b0}});
    assign full_s  = (count_r == DEPTH_C);
    // Fetch owns the port; a drain only happens on fetch-idle cycles.
    assign pop_s   = !empty_s && !fetch_busy;
    assign push_s  = st_valid && in_store_window(st_addr) && (st_be != 4'h0) && st_ready;

    assign st_ready    = !full_s || pop_s;
    assign pending     = !empty_s;
    assign drain_force = (starve_r == STARVE_MAX_C) && !empty_s;
    assign fetch_hold  = (fetch_pc[31:28] == 4'b0001) && hold_match_s;

    // Drive the IMEM write port from the head entry while draining.
    always_comb begin
        imem_we   = 4'h0;
        imem_addr = {ADDR_W{1'b0}};
        imem_din  = 32'h0;
        if (pop_s) begin
            imem_we   = be_mem_r[head_r];
            imem_addr = addr_mem_r[head_r];
            imem_din  = data_mem_r[head_r];
        end else begin
            imem_we   = 4'h0;
            imem_addr = {ADDR_W{1'b0}};
            imem_din  = 32'h0;
        end
    end

    // Read-after-write hazard: any occupied entry (head included) matching the fetch word.
    always_comb begin
        hold_match_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_r) &&
                (addr_mem_r[head_r + PTR_W'(i)] == fetch_pc[ADDR_W+1:2])) begin
                hold_match_s = 1'b1;
            end else begin
                hold_match_s = hold_match_s;
            end
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {ADDR_W{1'b0}};
                data_mem_r[i] <= 32'h0;
                be_mem_r[i]   <= 4'h0;
            end
        end else begin
            if (push_s) begin
                addr_mem_r[tail_r] <= st_addr[ADDR_W+1:2];
                data_mem_r[tail_r] <= st_data;
                be_mem_r[tail_r]   <= st_be;
                tail_r             <= tail_r + 1'b1;
            end
            if (pop_s) begin
                head_r <= head_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Count consecutive cycles a queued write is blocked by fetch, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_r <= {STV_W{1'b0}};
        end else if (empty_s || pop_s) begin
            starve_r <= {STV_W{1'b0}};
        end else if (fetch_busy && (starve_r != STARVE_MAX_C)) begin
            starve_r <= starve_r + 1'b1;
        end else begin
            starve_r <= starve_r;
        end
    end

endmodule

// File: tb/tb_imem_write_buffer.sv
// Scoreboard bench for imem_write_buffer: expected IMEM writes are queued by the
// stimulus and checked in order by an independent write-port monitor.
module tb_imem_write_buffer;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              st_valid;
    logic [31:0]       st_addr;
    logic [31:0]       st_data;
    logic [3:0]        st_be;
    logic              st_ready;
    logic              fetch_busy;
    logic [31:0]       fetch_pc;
    logic [3:0]        imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_din;
    logic              pending;
    logic              fetch_hold;
    logic              drain_force;

    imem_write_buffer #(.DEPTH(4), .ADDR_W(ADDR_W), .STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
        .st_ready(st_ready), .fetch_busy(fetch_busy), .fetch_pc(fetch_pc),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din),
        .pending(pending), .fetch_hold(fetch_hold), .drain_force(drain_force)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
        logic [3:0]        be;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every IMEM write must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we !== 4'h0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=we %h addr %h din %h required=no write",
                         imem_we, imem_addr, imem_din);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(imem_addr), 32'(e.a));
                chk("wr_data", imem_din, e.d);
                chk("wr_be", 32'(imem_we), 32'(e.be));
            end
        end
    end

    task automatic cycle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_be    = be;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        st_addr  = 32'h0;
        st_data  = 32'h0;
        st_be    = 4'h0;
    endtask

    initial begin
        reset      = 1'b0;
        st_valid   = 1'b0;
        st_addr    = 32'h0;
        st_data    = 32'h0;
        st_be      = 4'h0;
        fetch_busy = 1'b0;
        fetch_pc   = 32'h0;
        #12;
        chk("rst_st_ready", 32'(st_ready), 32'h1);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_we", 32'(imem_we), 32'h0);
        chk("rst_drain_force", 32'(drain_force), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cycle(1);

        // Single store, written the cycle after acceptance
        exp_q.push_back('{12'h004, 32'hDEADBEEF, 4'hF});
        store(32'h2000_0010, 32'hDEADBEEF, 4'hF);
        chk("single_we", 32'(imem_we), 32'hF);
        chk("single_addr", 32'(imem_addr), 32'h004);
        chk("single_din", imem_din, 32'hDEADBEEF);
        chk("single_pending", 32'(pending), 32'h1);
        cycle(1);
        chk("single_pending_after", 32'(pending), 32'h0);
        chk("single_we_after", 32'(imem_we), 32'h0);

        // Fill with fetch busy, reject a fifth store, then drain in order
        fetch_busy = 1'b1;
        exp_q.push_back('{12'h040, 32'h1111_1111, 4'hF});
        exp_q.push_back('{12'h041, 32'h2222_2222, 4'h1});
        exp_q.push_back('{12'h042, 32'h3333_3333, 4'h3});
        exp_q.push_back('{12'h043, 32'h4444_4444, 4'hC});
        store(32'h2000_0100, 32'h1111_1111, 4'hF);
        store(32'h2000_0104, 32'h2222_2222, 4'h1);
        store(32'h3000_0108, 32'h3333_3333, 4'h3);
        store(32'h2000_010C, 32'h4444_4444, 4'hC);
        chk("fill_st_ready", 32'(st_ready), 32'h0);
        chk("fill_pending", 32'(pending), 32'h1);
        store(32'h2000_0110, 32'h5555_5555, 4'hF);
        chk("fill_st_ready_5th", 32'(st_ready), 32'h0);
        fetch_busy = 1'b0;
        #1;
        chk("drain_st_ready", 32'(st_ready), 32'h1);
        chk("drain_first_we", 32'(imem_we), 32'hF);
        cycle(3);
        chk("drain_pending_3", 32'(pending), 32'h1);
        cycle(1);
        chk("drain_pending_4", 32'(pending), 32'h0);

        // Starvation: drain_force on the 8th blocked cycle, saturating
        fetch_busy = 1'b1;
        exp_q.push_back('{12'h3FF, 32'hCAFEF00D, 4'h6});
        store(32'h2000_0FFC, 32'hCAFEF00D, 4'h6);
        cycle(7);
        chk("starve_7", 32'(drain_force), 32'h0);
        cycle(1);
        chk("starve_8", 32'(drain_force), 32'h1);
        cycle(3);
        chk("starve_sat", 32'(drain_force), 32'h1);
        fetch_busy = 1'b0;
        #1;
        chk("starve_we", 32'(imem_we), 32'h6);
        cycle(1);
        chk("starve_clear", 32'(drain_force), 32'h0);
        chk("starve_pending", 32'(pending), 32'h0);

        // Hazard: fetch word matches a queued store
        fetch_busy = 1'b1;
        fetch_pc   = 32'h1000_0020;
        exp_q.push_back('{12'h008, 32'h0BADF00D, 4'hF});
        store(32'h3000_0020, 32'h0BADF00D, 4'hF);
        chk("hazard_hit", 32'(fetch_hold), 32'h1);
        fetch_pc = 32'h1000_0024;
        #1;
        chk("hazard_other_word", 32'(fetch_hold), 32'h0);
        fetch_pc = 32'h3000_0020;
        #1;
        chk("hazard_other_window", 32'(fetch_hold), 32'h0);
        fetch_pc = 32'h1000_0020;
        cycle(7);
        chk("starve_restart_7", 32'(drain_force), 32'h0);
        fetch_busy = 1'b0;
        #1;
        chk("hazard_popping", 32'(fetch_hold), 32'h1);
        cycle(1);
        chk("hazard_gone", 32'(fetch_hold), 32'h0);
        fetch_pc = 32'h0;

        // Filtering: outside window or empty byte enables
        store(32'h1000_0000, 32'hAAAA_AAAA, 4'hF);
        chk("filter_window", 32'(pending), 32'h0);
        store(32'h2000_0000, 32'hBBBB_BBBB, 4'h0);
        chk("filter_be0", 32'(pending), 32'h0);
        store(32'h4000_0000, 32'hCCCC_CCCC, 4'hF);
        chk("filter_high", 32'(pending), 32'h0);

        // Asynchronous reset with 3 queued entries
        fetch_busy = 1'b1;
        store(32'h2000_0200, 32'h0101_0101, 4'hF);
        store(32'h2000_0204, 32'h0202_0202, 4'hF);
        store(32'h2000_0208, 32'h0303_0303, 4'hF);
        fetch_pc = 32'h1000_0200;
        #1;
        chk("pre_rst_pending", 32'(pending), 32'h1);
        chk("pre_rst_hold", 32'(fetch_hold), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("arst_st_ready", 32'(st_ready), 32'h1);
        chk("arst_pending", 32'(pending), 32'h0);
        chk("arst_hold", 32'(fetch_hold), 32'h0);
        chk("arst_drain_force", 32'(drain_force), 32'h0);
        fetch_busy = 1'b0;
        #1;
        chk("arst_we", 32'(imem_we), 32'h0);
        chk("arst_addr", 32'(imem_addr), 32'h0);
        chk("arst_din", imem_din, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        cycle(3);
        chk("post_rst_pending", 32'(pending), 32'h0);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_write_buffer.md
Name: imem_write_buffer

Overview:
- Store-side writer for the instruction memory (IMEM), the counterpart of the fetch-side read-enable logic.
- Captures MEM-stage stores that hit the IMEM write window and queues them in a small FIFO.
- Drains the FIFO into the IMEM write port only on cycles when fetch is not reading IMEM; fetch always has port priority.
- Provides a fetch-hold for read-after-write hazards and a forced-drain request so a stream of fetches cannot starve queued writes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- ADDR_W, 12, IMEM word-address width.
- STARVE_MAX, 8, consecutive blocked cycles before a forced drain is requested.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; low clears all state.
- st_valid  in  1  MEM-stage store valid this cycle.
- st_addr  in  32  store byte address.
- st_data  in  32  store data, already lane-aligned.
- st_be  in  4  byte enables.
- st_ready  out  1  store can be accepted this cycle.
- fetch_busy  in  1  IF reads IMEM this cycle.
- fetch_pc  in  32  current fetch PC.
- imem_we  out  4  IMEM byte write enables.
- imem_addr  out  ADDR_W  IMEM word address.
- imem_din  out  32  IMEM write data.
- pending  out  1  FIFO non-empty.
- fetch_hold  out  1  fetch must stall due to a read-after-write hazard.
- drain_force  out  1  request that IF release the IMEM port next cycle.

Behaviour:
- Window decode: a store hits IMEM when st_addr[31:28] == 4'b001x (0x2 or 0x3). Non-hits are ignored entirely.
- Entry contents: {st_addr[ADDR_W+1:2], st_data, st_be}.
- Accept condition: st_valid, window hit, st_be != 0 and st_ready. A store with st_be == 0 is dropped and never enqueued.
- st_ready = !full OR (drain this cycle). Push and pop on the same edge is allowed when full; count stays unchanged.
- Drain condition: !empty AND !fetch_busy.
  - While draining, imem_we/imem_addr/imem_din are driven combinationally from the head entry. The write occurs at the rising edge, which also pops the head.
  - When not draining, imem_we = 0, and imem_addr/imem_din = 0.
- Latency: no bypass. A store accepted at edge N can be written at the earliest at edge N+1.
- pending = !empty.
- fetch_hold = fetch_pc[31:28] == 4'b0001 AND any valid entry's word address == fetch_pc[ADDR_W+1:2]. Combinational; the entry being popped this cycle still counts.
- Starve counter (width clog2(STARVE_MAX+1)):
  - Cleared on reset, on any pop, and whenever the FIFO is empty.
  - Increments each cycle with !empty AND fetch_busy, saturating at STARVE_MAX.
  - drain_force = (counter == STARVE_MAX) AND !empty.
- Head/tail pointers wrap modulo DEPTH. Full/empty are derived from a separate occupancy count of 0..DEPTH.
- Reset asserted mid-operation: all entries are discarded (queued writes lost), pointers/count/counter go to 0, and every output is 0 except st_ready = 1.
- Store order is preserved: FIFO order equals program order. Two entries to the same word are both written, in order.

Test Plan:
- Single store: 0x20000010, data 0xDEADBEEF, be 0xF, fetch_busy = 0 → cycle after accept: imem_we = 0xF, imem_addr = 0x004, imem_din = 0xDEADBEEF; pending returns to 0.
- Fill: 4 stores with fetch_busy = 1 → after the 4th, st_ready = 0 and a 5th store is not accepted. Release fetch_busy → 4 writes in order on 4 consecutive cycles; st_ready = 1 on the first drain cycle.
- Starvation: 1 entry with fetch_busy held high → drain_force rises on the 8th blocked cycle. Drop fetch_busy → write issues, then drain_force = 0 and the counter is 0.
- Hazard: queue a store to 0x30000020 with fetch_busy = 1 and fetch_pc = 0x10000020 → fetch_hold = 1. fetch_pc = 0x10000024 → fetch_hold = 0.
- Filtering: store to 0x10000000 or with be = 0 → no enqueue, and pending stays 0.
- Reset: reset pulsed low with 3 entries queued → all outputs 0 immediately (asynchronous), st_ready = 1, and no IMEM write after release.
